// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the convolution core sequencer: FSM states,
// instruction-word bit positions, the weight base address and the idle word.
package core_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WL0,
        WLOAD,
        AL0,
        EXEC,
        DRAIN,
        OFRD,
        ACC,
        ACCOUT,
        DONE,
        GAP
    } state_t;

    localparam int unsigned INST_W = 35;
    localparam int unsigned ADDR_W = 11;

    localparam int unsigned B_MODE       = 34;
    localparam int unsigned B_ACC        = 33;
    localparam int unsigned B_CEN_PMEM   = 32;
    localparam int unsigned B_WEN_PMEM   = 31;
    localparam int unsigned B_A_PMEM_LSB = 20;
    localparam int unsigned B_CEN_XMEM   = 19;
    localparam int unsigned B_WEN_XMEM   = 18;
    localparam int unsigned B_A_XMEM_LSB = 7;
    localparam int unsigned B_OFIFO_RD   = 6;
    localparam int unsigned B_IFIFO_WR   = 5;
    localparam int unsigned B_IFIFO_RD   = 4;
    localparam int unsigned B_L0_RD      = 3;
    localparam int unsigned B_L0_WR      = 2;
    localparam int unsigned B_EXECUTE    = 1;
    localparam int unsigned B_LOAD       = 0;

    localparam logic [ADDR_W-1:0] WEIGHT_BASE = 11'h400;

    // Word issued whenever no memory or array operation is wanted.
    function automatic logic [INST_W-1:0] idle_word(input logic mode);
        logic [INST_W-1:0] w;
        w               = '0;
        w[B_CEN_PMEM]   = 1'b1;
        w[B_WEN_PMEM]   = 1'b1;
        w[B_CEN_XMEM]   = 1'b1;
        w[B_WEN_XMEM]   = 1'b1;
        w[B_IFIFO_WR]   = 1'b0;
        w[B_IFIFO_RD]   = 1'b0;
        w[B_MODE]       = mode;
        return w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_sequencer_seq_counter.sv
// Loadable up-counter with a terminal-count flag against a runtime limit.
module seq_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Load takes priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer for the PE-array convolution core: weight load,
// activation load, execute, drain, psum write-back and final accumulation.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned row      = 8,
    parameter int unsigned col      = 8,
    parameter int unsigned len_nij  = 36,
    parameter int unsigned len_kij  = 9,
    parameter int unsigned len_onij = 16,
    parameter int unsigned gap      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_sel,
    input  logic              ofifo_valid,
    input  logic [10:0]       acc_addr,
    output logic [7:0]        acc_idx,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              out_valid,
    output logic              done
);

    localparam int unsigned PH_MAX = max_u(1, max_u(max_u(col - 1, len_nij - 1),
                                     max_u(max_u(row + col - 1, len_kij), gap - 1)));
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned KIJ_W  = (len_kij > 1) ? $clog2(len_kij) : 1;
    localparam int unsigned ONIJ_W = (len_onij > 1) ? $clog2(len_onij) : 1;

    if ((len_kij * len_nij > 2048) || (gap < 1) || (len_onij * len_kij > 256) ||
        (32'(WEIGHT_BASE) + len_kij * col > 2048)) begin : g_param_check
        $error("core_sequencer: parameters overflow address or index widths");
    end

    state_t             state;
    state_t             ret_state;
    logic               mode_q;
    logic [INST_W-1:0]  inst_nxt;

    logic [PH_W-1:0]    ph_cnt, ph_last;
    logic               ph_tc, ph_load, ph_en, ph_end, accept;
    logic [KIJ_W-1:0]   kij_cnt;
    logic               kij_tc, kij_load, kij_en;
    logic [ONIJ_W-1:0]  onij_cnt;
    logic               onij_tc, onij_load, onij_en;
    logic               acc_rd;

    // Per-state phase length (terminal count of the phase counter).
    always_comb begin
        ph_last = '0;
        case (state)
            WL0, WLOAD:      ph_last = PH_W'(col - 1);
            AL0, EXEC, OFRD: ph_last = PH_W'(len_nij - 1);
            DRAIN:           ph_last = PH_W'(row + col - 1);
            ACC:             ph_last = PH_W'(len_kij);
            ACCOUT, GAP:     ph_last = PH_W'(gap - 1);
            default:         ph_last = '0;
        endcase
    end

    // Counter control: OFRD only advances on words actually accepted.
    always_comb begin
        accept    = (state != OFRD) || ofifo_valid;
        ph_end    = ph_tc && accept;
        ph_load   = ph_end || (state == IDLE) || (state == DONE);
        ph_en     = accept;
        kij_load  = (state == IDLE);
        kij_en    = (state == OFRD) && ph_end && !kij_tc;
        onij_load = (state == IDLE);
        onij_en   = (state == ACCOUT) && ph_end && !onij_tc;
        acc_rd    = (state == ACC) && (32'(ph_cnt) < len_kij);
        acc_idx   = acc_rd ? 8'(32'(onij_cnt) * len_kij + 32'(ph_cnt)) : '0;
    end

    seq_counter #(.WIDTH(PH_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ph_load),
        .load_val ('0),
        .en       (ph_en),
        .last     (ph_last),
        .count    (ph_cnt),
        .tc       (ph_tc)
    );

    seq_counter #(.WIDTH(KIJ_W)) u_kij_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (kij_load),
        .load_val ('0),
        .en       (kij_en),
        .last     (KIJ_W'(len_kij - 1)),
        .count    (kij_cnt),
        .tc       (kij_tc)
    );

    seq_counter #(.WIDTH(ONIJ_W)) u_onij_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (onij_load),
        .load_val ('0),
        .en       (onij_en),
        .last     (ONIJ_W'(len_onij - 1)),
        .count    (onij_cnt),
        .tc       (onij_tc)
    );

    // Instruction word decoded from the current state; registered below.
    always_comb begin
        inst_nxt = idle_word(mode_q);
        case (state)
            IDLE: inst_nxt[B_MODE] = start ? mode_sel : mode_q;
            WL0: begin
                inst_nxt[B_CEN_XMEM] = 1'b0;
                inst_nxt[B_L0_WR]    = 1'b1;
                inst_nxt[B_A_XMEM_LSB +: ADDR_W] =
                    WEIGHT_BASE + 11'(32'(kij_cnt) * col + 32'(ph_cnt));
            end
            WLOAD: begin
                inst_nxt[B_L0_RD] = 1'b1;
                inst_nxt[B_LOAD]  = 1'b1;
            end
            AL0: begin
                inst_nxt[B_CEN_XMEM] = 1'b0;
                inst_nxt[B_L0_WR]    = 1'b1;
                inst_nxt[B_A_XMEM_LSB +: ADDR_W] = 11'(ph_cnt);
            end
            EXEC: begin
                inst_nxt[B_L0_RD]   = 1'b1;
                inst_nxt[B_EXECUTE] = 1'b1;
            end
            OFRD: begin
                if (ofifo_valid) begin
                    inst_nxt[B_OFIFO_RD] = 1'b1;
                    inst_nxt[B_CEN_PMEM] = 1'b0;
                    inst_nxt[B_WEN_PMEM] = 1'b0;
                    inst_nxt[B_A_PMEM_LSB +: ADDR_W] =
                        11'(32'(kij_cnt) * len_nij + 32'(ph_cnt));
                end
            end
            ACC: begin
                if (acc_rd) begin
                    inst_nxt[B_CEN_PMEM] = 1'b0;
                    inst_nxt[B_A_PMEM_LSB +: ADDR_W] = acc_addr;
                end
                // accumulate one cycle behind each psum read
                if (ph_cnt != '0) begin
                    inst_nxt[B_ACC] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Main FSM with registered inst/busy/out_valid/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ret_state <= IDLE;
            mode_q    <= 1'b0;
            inst      <= idle_word(1'b0);
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            inst      <= inst_nxt;
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mode_q <= mode_sel;
                    busy   <= 1'b1;
                    state  <= WL0;
                end
                WL0: if (ph_end) begin
                    state     <= GAP;
                    ret_state <= WLOAD;
                end
                WLOAD: if (ph_end) begin
                    state     <= GAP;
                    ret_state <= AL0;
                end
                AL0: if (ph_end) begin
                    state     <= GAP;
                    ret_state <= EXEC;
                end
                EXEC:  if (ph_end) state <= DRAIN;
                DRAIN: if (ph_end) state <= OFRD;
                OFRD: if (ph_end) begin
                    state     <= GAP;
                    ret_state <= kij_tc ? ACC : WL0;
                end
                GAP: if (ph_end) state <= ret_state;
                ACC: if (ph_end) state <= ACCOUT;
                ACCOUT: if (ph_end) begin
                    out_valid <= 1'b1;
                    state     <= onij_tc ? DONE : ACC;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer at default parameters.
module tb_core_sequencer;

    localparam logic [34:0] IDLE0     = 35'h1800C0000;
    localparam logic [34:0] WL0_FIRST = 35'h180060004;
    // 9 kij x (8+2+8+2+36+2+36+16+36+2) + 16 x (10+2) + DONE
    localparam int BUSY_CYCLES = 1525;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode_sel;
    logic        ofifo_valid;
    logic [10:0] acc_addr;
    logic [7:0]  acc_idx;
    logic [34:0] inst;
    logic        busy;
    logic        out_valid;
    logic        done;

    always #5 clk = ~clk;

    assign acc_addr = {3'b000, acc_idx};

    core_sequencer #(
        .row(8), .col(8), .len_nij(36), .len_kij(9), .len_onij(16), .gap(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode_sel    (mode_sel),
        .ofifo_valid (ofifo_valid),
        .acc_addr    (acc_addr),
        .acc_idx     (acc_idx),
        .inst        (inst),
        .busy        (busy),
        .out_valid   (out_valid),
        .done        (done)
    );

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    bit toggle_valid = 1'b0;
    logic mode_exp;
    int n_busy, n_acc, n_ov, n_done, bad_rd, bad_lag, bad_mode, last_ov_cyc, done_cyc;
    logic prev_rd;
    logic [10:0] wl0_q[$];
    logic [10:0] wr_q[$];
    logic [10:0] rd_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_busy = 0; n_acc = 0; n_ov = 0; n_done = 0;
        bad_rd = 0; bad_lag = 0; bad_mode = 0;
        last_ov_cyc = -10; done_cyc = -20; prev_rd = 1'b0;
        wl0_q.delete(); wr_q.delete(); rd_q.delete();
    endtask

    // Drive inputs at the falling edge, sample outputs 1 unit after the rising edge.
    task automatic step(input logic st);
        logic [10:0] a_pmem, a_xmem;
        logic wr, rd;
        @(negedge clk);
        start = st;
        ofifo_valid = toggle_valid ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        a_pmem = inst[30:20];
        a_xmem = inst[17:7];
        wr = !inst[32] && !inst[31];
        rd = !inst[32] && inst[31];
        if (busy) n_busy++;
        if (wr) begin
            wr_q.push_back(a_pmem);
            if (!inst[6] || !ofifo_valid) bad_rd++;
        end else if (inst[6]) begin
            bad_rd++;
        end
        if (rd) rd_q.push_back(a_pmem);
        if (inst[33]) begin
            n_acc++;
            if (!prev_rd) bad_lag++;
        end
        prev_rd = rd;
        if (inst[2] && !inst[19] && inst[18] && a_xmem >= 11'h400) wl0_q.push_back(a_xmem);
        if (busy && inst[34] !== mode_exp) bad_mode++;
        if (out_valid) begin n_ov++; last_ov_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; end
    endtask

    function automatic int seq_errors(input logic [10:0] q[$]);
        int bad = 0;
        foreach (q[i]) if (int'(q[i]) != i) bad++;
        return bad;
    endfunction

    task automatic run_conv(input string pfx, input logic mode, input int limit, input bit extra);
        int k;
        clear_stats();
        mode_sel = mode;
        mode_exp = mode;
        step(1'b1);
        mode_sel = ~mode;
        k = 0;
        while (n_done == 0 && k < limit) begin
            step(extra && (k == 3 || k == 700 || k == 1400 || k == 1524));
            k++;
        end
        repeat (4) step(1'b0);
        check({pfx, "_done_count"}, n_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        reset = 1'b1; start = 1'b0; mode_sel = 1'b0; ofifo_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_inst", inst, IDLE0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_acc_idx", acc_idx, 0);
        @(negedge clk);
        reset = 1'b0;

        // Full run, ofifo always valid, mode 1
        run_conv("a", 1'b1, 3000, 1'b0);
        check("a_busy_cycles", n_busy, BUSY_CYCLES);
        check("a_wl0_count", wl0_q.size(), 72);
        check("a_wl0_k0_first", wl0_q[0], 11'h400);
        check("a_wl0_k0_last", wl0_q[7], 11'h407);
        check("a_wl0_k8_first", wl0_q[64], 11'h440);
        check("a_wl0_k8_last", wl0_q[71], 11'h447);
        check("a_pmem_wr_count", wr_q.size(), 324);
        check("a_pmem_wr_k3_first", wr_q[108], 108);
        check("a_pmem_wr_k3_last", wr_q[143], 143);
        check("a_pmem_wr_seq", seq_errors(wr_q), 0);
        check("a_out_valid_count", n_ov, 16);
        check("a_done_after_ov", done_cyc, last_ov_cyc + 1);
        check("a_acc_rd_count", rd_q.size(), 144);
        check("a_acc_rd_o2_first", rd_q[18], 18);
        check("a_acc_rd_o2_last", rd_q[26], 26);
        check("a_acc_rd_seq", seq_errors(rd_q), 0);
        check("a_acc_count", n_acc, 144);
        check("a_acc_lag", bad_lag, 0);
        check("a_mode_bit", bad_mode, 0);
        check("a_ofifo_rd", bad_rd, 0);

        // ofifo_valid toggling 1,0,0,1
        toggle_valid = 1'b1;
        run_conv("b", 1'b0, 6000, 1'b0);
        toggle_valid = 1'b0;
        check("b_pmem_wr_count", wr_q.size(), 324);
        check("b_pmem_wr_seq", seq_errors(wr_q), 0);
        check("b_ofifo_rd_only_valid", bad_rd, 0);
        check("b_out_valid_count", n_ov, 16);
        check("b_stalled", n_busy > BUSY_CYCLES, 1);

        // Extra start pulses while busy are ignored
        run_conv("c", 1'b0, 3000, 1'b1);
        check("c_busy_cycles", n_busy, BUSY_CYCLES);
        check("c_pmem_wr_count", wr_q.size(), 324);
        check("c_out_valid_count", n_ov, 16);

        // Reset in the middle of EXEC
        clear_stats();
        mode_sel = 1'b0;
        mode_exp = 1'b0;
        step(1'b1);
        k = 0;
        while (!inst[1] && k < 300) begin step(1'b0); k++; end
        check("d_exec_reached", inst[1], 1);
        step(1'b0);
        step(1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("d_rst_inst", inst, IDLE0);
        check("d_rst_busy", busy, 0);
        check("d_rst_acc_idx", acc_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            step(1'b0);
            if (inst !== IDLE0 || busy !== 1'b0) bad++;
        end
        check("d_no_resume", bad, 0);
        step(1'b1);
        check("d_restart_busy", busy, 1);
        step(1'b0);
        check("d_restart_wl0_word", inst, WL0_FIRST);
        k = 0;
        while (n_done == 0 && k < 3000) begin step(1'b0); k++; end
        check("d_restart_done", n_done, 1);
        check("d_restart_pmem_wr", wr_q.size(), 324);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
